// File: rtl/smallalu_arbiter_pkg.sv
// Shared op-code constants and FSM state encoding for the small ALU arbiter.
package smallalu_arbiter_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_AND = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/smallalu_rr_pick.sv
// Combinational round-robin winner selection; search begins just after last_grant.
module smallalu_rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [1:0]      last_grant,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      grant_idx
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        // 2-bit index arithmetic wraps naturally for four requesters
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = last_grant + 2'(i);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smallalu_arbiter.sv
// Four-requester round-robin front end sharing one registered add/sub/xor/and unit.
module smallalu_arbiter
    import smallalu_arbiter_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_sel,
    input  logic [width*NREQ-1:0] req_a,
    input  logic [width*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_id,
    output logic [width-1:0]      rsp_data,
    input  logic                  rsp_ready,
    output logic                  busy
);

    state_t            state, state_nx;
    logic [1:0]        last_grant;
    logic [NREQ-1:0]   grant;
    logic [1:0]        grant_idx;
    logic              accept;
    logic [1:0]        cap_sel;
    logic [1:0]        cap_id;
    logic [width-1:0]  cap_a, cap_b;
    logic [width-1:0]  result, alu_out;

    smallalu_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_nx  = EXEC;
                end
            end
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        alu_out = '0;
        case (cap_sel)
            OP_ADD:  alu_out = cap_a + cap_b;
            OP_SUB:  alu_out = cap_a - cap_b;
            OP_XOR:  alu_out = cap_a ^ cap_b;
            OP_AND:  alu_out = cap_a & cap_b;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 2'(NREQ - 1);
            cap_sel    <= '0;
            cap_id     <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            result     <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                cap_id     <= grant_idx;
                cap_sel    <= req_sel[2*grant_idx +: 2];
                cap_a      <= req_a[width*grant_idx +: width];
                cap_b      <= req_b[width*grant_idx +: width];
            end
            if (state == EXEC) result <= alu_out;
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = cap_id;
    assign rsp_data  = result;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_smallalu_arbiter.sv
// Scoreboard bench: drivers push hand-computed responses, a monitor pops on each handshake.
module tb_smallalu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_sel = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_ready = 1'b1;
    logic        busy;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    smallalu_arbiter #(.width(8), .NREQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid && !prev_valid) begin
                if (q.size() == 0) check("stale_rsp_valid", 32'd1, 32'd0);
                else               check("latency", 32'(cyc - q[0].acc), 32'd2);
            end
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                e = q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 30 && !done; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Issue one op; after the accept the operands are scrambled to prove they were captured.
    task automatic do_op(input int id, input logic [1:0] sel, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_data);
        bit   got = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        req_sel[2*id +: 2] = sel;
        req_a[8*id +: 8]   = a;
        req_b[8*id +: 8]   = b;
        req_valid[id]      = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                got = 1'b1;
                check("grant_onehot", 32'(req_ready), 32'(4'b0001 << id));
                e.id = 2'(id); e.data = exp_data; e.acc = cyc;
                q.push_back(e);
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[id]    = 1'b0;
        req_a[8*id +: 8] = ~a;
        req_b[8*id +: 8] = ~b;
    endtask

    // All four requesters held high with add ops: a = 0x10*i, b = 1.
    task automatic contention();
        logic [7:0] exp_dat [4] = '{8'h01, 8'h11, 8'h21, 8'h31};
        int   last_acc = 0;
        bit   got;
        int   idx;
        exp_t e;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req_sel[2*i +: 2] = 2'd0;
            req_a[8*i +: 8]   = 8'(8'h10 * i);
            req_b[8*i +: 8]   = 8'h01;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            idx = -1;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                if ((req_ready & req_valid) != 4'b0000) got = 1'b1;
            end
            if (!got) begin
                check("contention_timeout", 32'd0, 32'd1);
            end else begin
                for (int j = 0; j < 4; j++) if (req_ready[j]) idx = j;
                check("rr_order", 32'(idx), 32'(k % 4));
                if (k > 0) check("accept_spacing", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                e.id = 2'(k % 4); e.data = exp_dat[k % 4]; e.acc = cyc;
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_idle();
    endtask

    initial begin
        bit   got;
        exp_t e;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        contention();

        do_op(2, 2'd0, 8'hFF, 8'h01, 8'h00);
        wait_idle();

        do_op(1, 2'd2, 8'hA5, 8'h3C, 8'h99);
        wait_idle();
        do_op(1, 2'd3, 8'hA5, 8'h3C, 8'h24);
        wait_idle();

        // Backpressure: response held while requester 3 waits.
        rsp_ready = 1'b0;
        do_op(0, 2'd1, 8'h00, 8'h01, 8'hFF);
        req_sel[7:6]   = 2'd3;
        req_a[31:24]   = 8'hF0;
        req_b[31:24]   = 8'h3C;
        req_valid[3]   = 1'b1;
        @(negedge clk);
        check("exec_no_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data",  32'(rsp_data),  32'hFF);
            check("bp_no_ready",  32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy",  32'(busy),      32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b1000);
        e.id = 2'd3; e.data = 8'h30; e.acc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_idle();

        // Reset during EXEC aborts the op; no response is queued for it.
        @(posedge clk); #1;
        req_sel[3:2]  = 2'd0;
        req_a[15:8]   = 8'h01;
        req_b[15:8]   = 8'h01;
        req_valid[1]  = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) got = 1'b1;
        end
        check("abort_accept", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        check("abort_busy_exec", 32'(busy), 32'd1);
        reset = 1'b0;
        req_valid = 4'b0000;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_id",    32'(rsp_id),    32'd0);
        check("abort_rsp_data",  32'(rsp_data),  32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle", 32'(busy), 32'd0);
        contention();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
